imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Interfaces used by imem_loader.
//   imem_loader_stream_if : byte stream with valid/ready handshake
//                           (master = byte source, slave = loader).
//   imem_loader_wr_if     : instruction-memory write port
//                           (master = loader, slave = memory).
`timescale 1ns/1ps

interface imem_loader_stream_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

interface imem_loader_wr_if #(
  parameter int ADDR_W = 8
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input imem_we, input imem_addr, input imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
// Frame = N (16-bit, little-endian) followed by N little-endian 32-bit words,
// written to consecutive word addresses starting at 0. The CPU is held in
// stall (cpu_run = 0) until a complete image has been accepted.
// Optional feature macro: LOADER_CSUM_EN adds a trailing XOR checksum byte
// covering every header and payload byte; a mismatch ends in ERR.
`timescale 1ns/1ps

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  imem_loader_stream_if.slave  stream,
  imem_loader_wr_if.master     wr,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_run
);

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
`ifdef LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  // State entered once the last payload word (or an empty header) is taken.
`ifdef LOADER_CSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  // Largest image that fits: 2^ADDR_W words.
  localparam int unsigned CAP = 2 ** ADDR_W;

  state_t            state;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   widx;
  logic [1:0]        lane;
  logic [23:0]       partial;
  logic              accept;
  logic              rearm;
  logic              last_word;
  logic [15:0]       n_full;

  assign stream.s_ready = (state != ST_DONE) && (state != ST_ERR);
  assign done           = (state == ST_DONE);
  assign err            = (state == ST_ERR);

  assign accept    = stream.s_valid && stream.s_ready;
  assign rearm     = start && ((state == ST_DONE) || (state == ST_ERR));
  // Full word count as it will be latched on the HDR1 accept.
  assign n_full    = {stream.s_data, n_words[7:0]};
  // widx holds the index of the word being assembled; N-1 is the last one.
  assign last_word = ((32'(widx) + 32'd1) == 32'(n_words));

`ifdef LOADER_CSUM_EN
  logic [7:0] csum;

  // Running XOR over header and payload bytes; cleared on re-arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'd0;
    end else if (rearm) begin
      csum <= 8'd0;
    end else if (accept && ((state == ST_HDR0) || (state == ST_HDR1) ||
                            (state == ST_PAYLOAD))) begin
      csum <= csum ^ stream.s_data;
    end
  end
`endif

  // Frame FSM, word assembly, registered memory write port and CPU release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HDR0;
      n_words       <= 16'd0;
      widx          <= '0;
      lane          <= 2'd0;
      partial       <= 24'd0;
      wr.imem_we    <= 1'b0;
      wr.imem_addr  <= '0;
      wr.imem_wdata <= 32'd0;
      cpu_run       <= 1'b0;
    end else begin
      wr.imem_we <= 1'b0;
      // Set only on an edge that starts and ends in DONE.
      cpu_run    <= (state == ST_DONE) && !start;

      case (state)
        ST_HDR0: begin
          if (accept) begin
            n_words[7:0] <= stream.s_data;
            state        <= ST_HDR1;
          end
        end

        ST_HDR1: begin
          if (accept) begin
            n_words[15:8] <= stream.s_data;
            if (32'(n_full) > CAP) begin
              state <= ST_ERR;
            end else if (n_full == 16'd0) begin
              state <= ST_TAIL;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (accept) begin
            if (lane == 2'd3) begin
              wr.imem_we    <= 1'b1;
              wr.imem_addr  <= widx[ADDR_W-1:0];
              wr.imem_wdata <= {stream.s_data, partial};
              widx          <= widx + 1'b1;
              lane          <= 2'd0;
              if (last_word) begin
                state <= ST_TAIL;
              end
            end else begin
              partial[8*lane +: 8] <= stream.s_data;
              lane                 <= lane + 2'd1;
            end
          end
        end

`ifdef LOADER_CSUM_EN
        ST_CSUM: begin
          if (accept) begin
            state <= (stream.s_data == csum) ? ST_DONE : ST_ERR;
          end
        end
`endif

        ST_DONE, ST_ERR: begin
          if (start) begin
            state   <= ST_HDR0;
            n_words <= 16'd0;
            widx    <= '0;
            lane    <= 2'd0;
          end
        end

        default: state <= ST_HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: two instances (ADDR_W = 8 and ADDR_W = 2) share
// one stimulus driver selected by 'sel'. Expected memory writes are queued
// when the 4th byte of a word is driven and popped when imem_we is seen.
`timescale 1ns/1ps

module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drv_start;
  logic       drv_valid;
  logic [7:0] drv_data;
  int         sel;

  always #5 clk = ~clk;

  imem_loader_stream_if                s8 ();
  imem_loader_wr_if #(.ADDR_W(8))      w8 ();
  imem_loader_stream_if                s2 ();
  imem_loader_wr_if #(.ADDR_W(2))      w2 ();

  logic start8, start2;
  logic done8, err8, run8, done2, err2, run2;

  assign s8.s_valid = drv_valid && (sel == 0);
  assign s8.s_data  = drv_data;
  assign s2.s_valid = drv_valid && (sel == 1);
  assign s2.s_data  = drv_data;
  assign start8     = drv_start && (sel == 0);
  assign start2     = drv_start && (sel == 1);

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .stream  (s8.slave),
    .wr      (w8.master),
    .done    (done8),
    .err     (err8),
    .cpu_run (run8)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start2),
    .stream  (s2.slave),
    .wr      (w2.master),
    .done    (done2),
    .err     (err2),
    .cpu_run (run2)
  );

  // Outputs of the currently selected instance.
  logic        rdy, we, done_w, err_w, run_w;
  logic [31:0] addr_w, wdata_w;
  always_comb begin
    rdy     = (sel == 0) ? s8.s_ready    : s2.s_ready;
    we      = (sel == 0) ? w8.imem_we    : w2.imem_we;
    done_w  = (sel == 0) ? done8         : done2;
    err_w   = (sel == 0) ? err8          : err2;
    run_w   = (sel == 0) ? run8          : run2;
    addr_w  = (sel == 0) ? 32'(w8.imem_addr) : 32'(w2.imem_addr);
    wdata_w = (sel == 0) ? w8.imem_wdata : w2.imem_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  task automatic sb_pop(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    check_val("wr_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("wr_addr", a, e.addr);
      check_val("wr_data", d, e.data);
    end
  endtask

  // Write monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (w8.imem_we === 1'b1) sb_pop(32'(w8.imem_addr), w8.imem_wdata);
  end
  always @(negedge clk) begin
    if (w2.imem_we === 1'b1) sb_pop(32'(w2.imem_addr), w2.imem_wdata);
  end

  logic [31:0] img [0:255];

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      drv_valid = 1'b0;
      @(posedge clk); #1;
    end
    check_val("s_ready", 32'(rdy), 32'd1);
    drv_valid = 1'b1;
    drv_data  = b;
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  task automatic pulse_start();
    drv_start = 1'b1;
    @(posedge clk); #1;
    drv_start = 1'b0;
    check_val("rearm_done", 32'(done_w), 32'd0);
    check_val("rearm_err", 32'(err_w), 32'd0);
    check_val("rearm_ready", 32'(rdy), 32'd1);
  endtask

  task automatic run_frame(input int n, input bit gap, input bit bad);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] nn;
    logic        exp_we;
    logic [31:0] word;
    nn = 16'(n);
    cs = 8'd0;
    send_byte(nn[7:0], gap);  cs ^= nn[7:0];
    send_byte(nn[15:8], gap); cs ^= nn[15:8];
    for (int i = 0; i < n; i++) begin
      word = img[i];
      for (int k = 0; k < 4; k++) begin
        b   = word[8*k +: 8];
        cs ^= b;
        if (k == 3) sb.push_back('{32'(i), word});
        send_byte(b, gap);
      end
    end
`ifdef LOADER_CSUM_EN
    send_byte(bad ? (cs ^ 8'h01) : cs, gap);
    exp_we = 1'b0;
`else
    exp_we = (n > 0);
`endif
    check_val("last_we", 32'(we), 32'(exp_we));
    check_val("done_edge", 32'(done_w), 32'(!bad));
    check_val("err_edge", 32'(err_w), 32'(bad));
    check_val("run_lag", 32'(run_w), 32'd0);
    @(posedge clk); #1;
    check_val("run", 32'(run_w), 32'(!bad));
    check_val("ready_hold", 32'(rdy), 32'd0);
    check_val("we_single", 32'(we), 32'd0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    drv_start = 1'b0;
    drv_valid = 1'b0;
    drv_data  = 8'd0;
    sel       = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(rdy), 32'd1);
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_addr", addr_w, 32'd0);
    check_val("rst_wdata", wdata_w, 32'd0);
    check_val("rst_done", 32'(done_w), 32'd0);
    check_val("rst_err", 32'(err_w), 32'd0);
    check_val("rst_run", 32'(run_w), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word image, full throughput.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0041_00B3;
    run_frame(2, 1'b0, 1'b0);
    check_val("addr_hold", addr_w, 32'd1);
    check_val("wdata_hold", wdata_w, 32'h0041_00B3);
    pulse_start();

    // Same image with s_valid toggling.
    run_frame(2, 1'b1, 1'b0);
    pulse_start();

    // Empty image.
    run_frame(0, 1'b0, 1'b0);
    pulse_start();

    // N = 257 exceeds capacity of 256 words.
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check_val("ovf_err", 32'(err_w), 32'd1);
    check_val("ovf_ready", 32'(rdy), 32'd0);
    check_val("ovf_we", 32'(we), 32'd0);
    check_val("ovf_done", 32'(done_w), 32'd0);
    drv_valid = 1'b1;
    drv_data  = 8'h55;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    check_val("err_hold", 32'(err_w), 32'd1);
    pulse_start();

    // Full capacity image on the 8-bit instance.
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    run_frame(256, 1'b0, 1'b0);
    check_val("cap_last_addr", addr_w, 32'd255);
    pulse_start();

    // ADDR_W = 2: exactly four words fit, five do not.
    sel = 1;
    for (int i = 0; i < 4; i++) img[i] = 32'(i + 1);
    run_frame(4, 1'b0, 1'b0);
    check_val("a2_last_addr", addr_w, 32'd3);
    pulse_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    check_val("a2_ovf_err", 32'(err_w), 32'd1);
    check_val("a2_ovf_we", 32'(we), 32'd0);
    pulse_start();
    sel = 0;

`ifdef LOADER_CSUM_EN
    // Checksum good (0x01) then bad (0x00).
    img[0] = 32'hDDCC_BBAA;
    run_frame(1, 1'b0, 1'b0);
    pulse_start();
    run_frame(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_val("csum_bad_run", 32'(run_w), 32'd0);
    pulse_start();
`endif

    // Reset in the middle of a payload.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0041_00B3;
    run_frame(2, 1'b0, 1'b0);
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    check_val("pre_rst_addr", addr_w, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_addr", addr_w, 32'd0);
    check_val("mid_rst_wdata", wdata_w, 32'd0);
    check_val("mid_rst_we", 32'(we), 32'd0);
    check_val("mid_rst_ready", 32'(rdy), 32'd1);
    check_val("mid_rst_done", 32'(done_w), 32'd0);
    check_val("mid_rst_run", 32'(run_w), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(2, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
